program_counter_stack: RTL and testbench

//   Parametrised program counter for the 8-bit CPU: next generation of the 4-bit SAP-style PC.

---
 rtl/program_counter_stack.sv | 101 ++++++++++
 tb/tb_program_counter_stack.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_counter_stack.sv
// Parametrised program counter with relative jump and a hardware call/return stack.
// One action per clock, priority lp > call > ret > jr > cp; bus drive is split into out/oe.
module program_counter_stack #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic                       clk_i,
  input  logic                       clr_i,
  input  logic                       cp_i,
  input  logic                       lp_i,
  input  logic                       jr_i,
  input  logic                       call_i,
  input  logic                       ret_i,
  input  logic                       ep_i,
  input  logic [WIDTH-1:0]           bus_in_i,
  output logic [WIDTH-1:0]           bus_out_o,
  output logic                       bus_oe_o,
  output logic [WIDTH-1:0]           pc_o,
  output logic                       tc_o,
  output logic [$clog2(DEPTH+1)-1:0] sp_o,
  output logic                       stk_full_o,
  output logic                       stk_empty_o,
  output logic                       stk_err_o
);

  localparam int unsigned SpW  = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SpW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic             push;
  logic             full, empty;
  logic [IdxW-1:0]  push_idx, pop_idx;

  assign full     = (sp_q == SpW'(DEPTH));
  assign empty    = (sp_q == '0);
  assign push_idx = IdxW'(sp_q);
  assign pop_idx  = IdxW'(sp_q - SpW'(1));

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    if (lp_i) begin
      pc_d = bus_in_i;
    end else if (call_i) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        push = 1'b1;
        sp_d = sp_q + SpW'(1);
        pc_d = bus_in_i;
      end
    end else if (ret_i) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        pc_d = stack_q[pop_idx];
        sp_d = sp_q - SpW'(1);
      end
    end else if (jr_i) begin
      // Modular WIDTH-bit add equals pc + sign_extend(bus_in) mod 2^WIDTH.
      pc_d = pc_q + bus_in_i;
    end else if (cp_i) begin
      pc_d = pc_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      pc_q  <= WIDTH'(RESET_ADDR);
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack storage needs no reset; contents are only read below sp.
  always_ff @(posedge clk_i) begin
    if (push && !clr_i) begin
      stack_q[push_idx] <= pc_q;
    end
  end

  assign bus_out_o   = pc_q;
  assign bus_oe_o    = ep_i;
  assign pc_o        = pc_q;
  assign tc_o        = &pc_q;
  assign sp_o        = sp_q;
  assign stk_full_o  = full;
  assign stk_empty_o = empty;
  assign stk_err_o   = err_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Randomised and directed bench for program_counter_stack against a queue-based model.
module tb_program_counter_stack;

  logic       clk_i = 1'b0;
  logic       clr_i, cp_i, lp_i, jr_i, call_i, ret_i, ep_i;
  logic [3:0] bus_in_i;
  logic [3:0] bus_out_o, pc_o;
  logic       bus_oe_o, tc_o, stk_full_o, stk_empty_o, stk_err_o;
  logic [2:0] sp_o;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_pc;
  logic [3:0] m_stk[$];
  bit         m_err;

  logic [10:0] obs;
  assign obs = {pc_o, sp_o, stk_err_o, tc_o, stk_full_o, stk_empty_o};

  program_counter_stack #(
    .WIDTH     (4),
    .DEPTH     (4),
    .RESET_ADDR(0)
  ) dut (
    .clk_i      (clk_i),
    .clr_i      (clr_i),
    .cp_i       (cp_i),
    .lp_i       (lp_i),
    .jr_i       (jr_i),
    .call_i     (call_i),
    .ret_i      (ret_i),
    .ep_i       (ep_i),
    .bus_in_i   (bus_in_i),
    .bus_out_o  (bus_out_o),
    .bus_oe_o   (bus_oe_o),
    .pc_o       (pc_o),
    .tc_o       (tc_o),
    .sp_o       (sp_o),
    .stk_full_o (stk_full_o),
    .stk_empty_o(stk_empty_o),
    .stk_err_o  (stk_err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [10:0] expv();
    logic [3:0] p;
    logic [2:0] s;
    p = 4'(m_pc);
    s = 3'(m_stk.size());
    return {p, s, m_err, (m_pc == 15), (m_stk.size() == 4), (m_stk.size() == 0)};
  endfunction

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit l, c, j, ca, r, input int b);
    int s;
    if (l) m_pc = b;
    else if (ca) begin
      if (m_stk.size() == 4) m_err = 1'b1;
      else begin
        m_stk.push_back(4'(m_pc));
        m_pc = b;
      end
    end else if (r) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else m_pc = int'(m_stk.pop_back());
    end else if (j) begin
      s = (b >= 8) ? b - 16 : b;
      m_pc = (m_pc + s + 16) % 16;
    end else if (c) m_pc = (m_pc + 1) % 16;
  endtask

  task automatic cycle(input bit l, c, j, ca, r, input logic [3:0] b);
    lp_i = l; cp_i = c; jr_i = j; call_i = ca; ret_i = r; bus_in_i = b;
    @(posedge clk_i);
    #1;
    model_step(l, c, j, ca, r, int'(b));
    lp_i = 0; cp_i = 0; jr_i = 0; call_i = 0; ret_i = 0;
  endtask

  task automatic do_reset();
    clr_i = 1'b1;
    #1;
    model_reset();
    @(posedge clk_i);
    #1;
    clr_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== expv() || pc_o !== 4'd0)
      $display("FAIL reset_init: got %h expected %h", obs, expv());
    if (obs !== expv() || pc_o !== 4'd0) errors++;
    cycle(0, 0, 0, 0, 1, 4'd0);          // underflow sets err
    cycle(0, 0, 0, 1, 0, 4'd4);          // sp=1, pc=4
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 4'd0);
    checks++;
    if (pc_o !== 4'd7 || sp_o !== 3'd1 || stk_err_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_precount: pc=%h sp=%0d err=%b expected 7/1/1", pc_o, sp_o, stk_err_o);
    end
    cp_i = 1'b1;
    #2;
    clr_i = 1'b1;
    #1;
    model_reset();
    checks++;
    if (pc_o !== 4'd0 || sp_o !== 3'd0 || stk_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: pc=%h sp=%0d err=%b expected 0/0/0", pc_o, sp_o, stk_err_o);
    end
    @(posedge clk_i);
    #1;
    clr_i = 1'b0;
    cp_i  = 1'b0;
    checks++;
    if (obs !== expv()) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", obs, expv());
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 1, 0, 0, 0, 4'd0);
      checks++;
      if (obs !== expv() || pc_o !== 4'(i % 16) || tc_o !== (i == 15)) begin
        errors++;
        $display("FAIL count_wrap[%0d]: pc=%h tc=%b expected pc=%h tc=%b", i, pc_o, tc_o,
                 4'(i % 16), (i == 15));
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    cycle(1, 0, 0, 0, 0, 4'd3);
    cycle(1, 1, 0, 1, 0, 4'd9);
    checks++;
    if (obs !== expv() || pc_o !== 4'd9 || sp_o !== 3'd0) begin
      errors++;
      $display("FAIL priority_lp: pc=%h sp=%0d expected pc=9 sp=0", pc_o, sp_o);
    end
    cycle(0, 1, 1, 0, 0, 4'hE);
    checks++;
    if (obs !== expv() || pc_o !== 4'd7) begin
      errors++;
      $display("FAIL priority_jr: pc=%h expected 7", pc_o);
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    cycle(1, 0, 0, 0, 0, 4'd2);
    cycle(0, 0, 0, 1, 0, 4'hA);
    checks++;
    if (obs !== expv() || pc_o !== 4'hA || sp_o !== 3'd1) begin
      errors++;
      $display("FAIL call: pc=%h sp=%0d expected A/1", pc_o, sp_o);
    end
    cycle(0, 1, 0, 0, 0, 4'd0);
    checks++;
    if (pc_o !== 4'hB) begin
      errors++;
      $display("FAIL call_count: pc=%h expected B", pc_o);
    end
    cycle(0, 0, 0, 0, 1, 4'd0);
    checks++;
    if (obs !== expv() || pc_o !== 4'd2 || sp_o !== 3'd0 || stk_empty_o !== 1'b1) begin
      errors++;
      $display("FAIL ret: pc=%h sp=%0d empty=%b expected 2/0/1", pc_o, sp_o, stk_empty_o);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] saved;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 4'($urandom_range(0, 15)));
    checks++;
    if (obs !== expv() || stk_full_o !== 1'b1 || stk_err_o !== 1'b0) begin
      errors++;
      $display("FAIL overflow_fill: got %h expected %h", obs, expv());
    end
    saved = 4'(m_pc);
    cycle(0, 0, 0, 1, 0, 4'd5);
    checks++;
    if (obs !== expv() || pc_o !== saved || sp_o !== 3'd4 || stk_err_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_call: pc=%h sp=%0d err=%b expected %h/4/1", pc_o, sp_o,
               stk_err_o, saved);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 1, 4'd0);
      checks++;
      if (obs !== expv() || stk_err_o !== 1'b1) begin
        errors++;
        $display("FAIL overflow_ret[%0d]: got %h expected %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_underflow_bus();
    do_reset();
    cycle(1, 0, 0, 0, 0, 4'd6);
    cycle(0, 0, 0, 0, 1, 4'd0);
    checks++;
    if (obs !== expv() || pc_o !== 4'd6 || stk_err_o !== 1'b1) begin
      errors++;
      $display("FAIL underflow: pc=%h err=%b expected 6/1", pc_o, stk_err_o);
    end
    for (int i = 0; i < 4; i++) begin
      ep_i = i[0] ? 1'b0 : 1'b1;
      #1;
      checks++;
      if (bus_oe_o !== ep_i || bus_out_o !== 4'(m_pc)) begin
        errors++;
        $display("FAIL bus_oe[%0d]: oe=%b out=%h expected %b/%h", i, bus_oe_o, bus_out_o,
                 ep_i, 4'(m_pc));
      end
      cycle(0, 1, 0, 0, 0, 4'd0);
    end
    ep_i = 1'b0;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ep_i = 1'($urandom_range(0, 1));
      cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
      checks++;
      if (obs !== expv() || bus_out_o !== pc_o || bus_oe_o !== ep_i) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random[%0d]: got %h expected %h", i, obs, expv());
      end
      if (i == 200) do_reset();
    end
    ep_i = 1'b0;
  endtask

  initial begin
    clr_i = 1'b0; cp_i = 0; lp_i = 0; jr_i = 0; call_i = 0; ret_i = 0; ep_i = 0;
    bus_in_i = '0;
    model_reset();
    test_reset();
    test_count_wrap();
    test_priority();
    test_call_ret();
    test_overflow();
    test_underflow_bus();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
